// File: rtl/chacha_keystream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : chacha_keystream_serializer
// Description : Takes finished 512-bit ChaCha keystream blocks into a two-slot
//               ping-pong buffer and streams them out one word per cycle over
//               valid/ready. Owns the block counter fed back to the state
//               generator. Optional macro CHACHA_KS_XOR_EN adds a plaintext
//               input and a combinational ciphertext output.
// Revision    : 1.0 - initial release
// ============================================================================
module chacha_keystream_serializer #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 16
) (
    input  logic                           clk,
    input  logic                           clrStream,
    input  logic                           ctrLoad,
    input  logic [31:0]                    ctrInit,
    output logic [31:0]                    blockCtr,
    input  logic [NWORDS-1:0][WORD_W-1:0]  blkIn,
    input  logic                           blkValid,
    output logic                           blkReady,
    output logic [WORD_W-1:0]              ksWord,
    output logic                           ksValid,
    input  logic                           ksReady,
    output logic                           ksLast,
    output logic                           ctrWrap
`ifdef CHACHA_KS_XOR_EN
    ,
    input  logic [WORD_W-1:0]              ptWord,
    output logic [WORD_W-1:0]              ctWord
`endif
);

    localparam int               IDX_W      = $clog2(NWORDS);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_t;

    occ_t                          r_occ;
    occ_t                          w_occNext;
    logic [NWORDS-1:0][WORD_W-1:0] r_slot [2];
    logic                          r_wrSel;
    logic                          r_rdSel;
    logic [IDX_W-1:0]              r_rdIdx;
    logic [31:0]                   r_blockCtr;
    logic                          r_ctrWrap;

    logic                          w_accept;
    logic                          w_pop;
    logic                          w_finalPop;

    // Handshake decode; blkReady must not depend on blkValid.
    assign blkReady   = (r_occ != S_TWO) & ~r_ctrWrap & ~clrStream;
    assign ksValid    = (r_occ != S_EMPTY);
    assign w_accept   = blkValid & blkReady;
    assign w_pop      = ksValid & ksReady;
    assign w_finalPop = w_pop & ksLast;

    // Output word is read straight from the registered slot; forced to 0 when idle.
    assign ksWord   = ksValid ? r_slot[r_rdSel][r_rdIdx] : '0;
    assign ksLast   = ksValid & (r_rdIdx == c_LAST_IDX);
    assign blockCtr = r_blockCtr;
    assign ctrWrap  = r_ctrWrap;

`ifdef CHACHA_KS_XOR_EN
    // Ciphertext follows the keystream handshake; reads 0 when no word is valid.
    assign ctWord = ksValid ? (ksWord ^ ptWord) : '0;
`endif

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (clrStream) r_occ <= S_EMPTY;
        else           r_occ <= w_occNext;
    end

    // Occupancy next state: accept adds a block, final pop removes one.
    always_comb begin
        w_occNext = r_occ;
        case (r_occ)
            S_EMPTY: if (w_accept)                    w_occNext = S_ONE;
            S_ONE: begin
                if (w_accept && !w_finalPop)          w_occNext = S_TWO;
                else if (w_finalPop && !w_accept)     w_occNext = S_EMPTY;
            end
            S_TWO:   if (w_finalPop)                  w_occNext = S_ONE;
            default:                                  w_occNext = S_EMPTY;
        endcase
    end

    // Block storage; the write slot never aliases the slot being drained.
    always_ff @(posedge clk) begin
        if (w_accept) r_slot[r_wrSel] <= blkIn;
    end

    // Slot selectors and read index.
    always_ff @(posedge clk) begin
        if (clrStream) begin
            r_wrSel <= 1'b0;
            r_rdSel <= 1'b0;
            r_rdIdx <= '0;
        end else begin
            if (w_accept) r_wrSel <= ~r_wrSel;
            if (w_finalPop) begin
                r_rdIdx <= '0;
                r_rdSel <= ~r_rdSel;
            end else if (w_pop) begin
                r_rdIdx <= r_rdIdx + 1'b1;
            end
        end
    end

    // Block counter: a load (only while empty) beats the per-block increment.
    always_ff @(posedge clk) begin
        if (clrStream) begin
            r_blockCtr <= '0;
            r_ctrWrap  <= 1'b0;
        end else if (ctrLoad && (r_occ == S_EMPTY)) begin
            r_blockCtr <= ctrInit;
            r_ctrWrap  <= 1'b0;
        end else if (w_accept) begin
            r_blockCtr <= r_blockCtr + 32'd1;
            if (r_blockCtr == 32'hFFFF_FFFF) r_ctrWrap <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chacha_keystream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_chacha_keystream_serializer
// Description : Directed, table-driven bench for chacha_keystream_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chacha_keystream_serializer;

    logic              clk;
    logic              clrStream;
    logic              ctrLoad;
    logic [31:0]       ctrInit;
    logic [31:0]       blockCtr;
    logic [15:0][31:0] blkIn;
    logic              blkValid;
    logic              blkReady;
    logic [31:0]       ksWord;
    logic              ksValid;
    logic              ksReady;
    logic              ksLast;
    logic              ctrWrap;
`ifdef CHACHA_KS_XOR_EN
    logic [31:0]       ptWord;
    logic [31:0]       ctWord;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    chacha_keystream_serializer #(.WORD_W(32), .NWORDS(16)) dut (
        .clk       (clk),
        .clrStream (clrStream),
        .ctrLoad   (ctrLoad),
        .ctrInit   (ctrInit),
        .blockCtr  (blockCtr),
        .blkIn     (blkIn),
        .blkValid  (blkValid),
        .blkReady  (blkReady),
        .ksWord    (ksWord),
        .ksValid   (ksValid),
        .ksReady   (ksReady),
        .ksLast    (ksLast),
        .ctrWrap   (ctrWrap)
`ifdef CHACHA_KS_XOR_EN
        ,
        .ptWord    (ptWord),
        .ctWord    (ctWord)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        load;
        logic [31:0] init;
        logic        bv;
        logic        rdy;
        logic [31:0] base;
        logic        e_valid;
        logic [31:0] e_word;
        logic        e_last;
        logic        e_brdy;
        logic [31:0] e_ctr;
        logic        e_wrap;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_blk(input logic [31:0] base);
        for (int i = 0; i < 16; i++) blkIn[i] = base + 32'(i);
    endtask

    task automatic do_reset();
        clrStream = 1'b1;
        ctrLoad   = 1'b0;
        blkValid  = 1'b0;
        ksReady   = 1'b0;
        step();
        clrStream = 1'b0;
        #1;
    endtask

    // Drain one full block with ksReady held high, checking every word.
    task automatic drain(input string tag, input logic [31:0] base);
        ksReady = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s valid%0d", tag, k), 32'(ksValid), 32'd1);
            chk($sformatf("%s word%0d", tag, k), ksWord, base + 32'(k));
            chk($sformatf("%s last%0d", tag, k), 32'(ksLast), 32'(k == 15));
`ifdef CHACHA_KS_XOR_EN
            chk($sformatf("%s ct%0d", tag, k), ctWord, ~(base + 32'(k)));
`endif
            step();
        end
        chk($sformatf("%s idle", tag), 32'(ksValid), 32'd0);
    endtask

    initial begin
        int         exp_i;
        int         cyc;
        logic [3:0] pat;

        clrStream = 1'b1;
        ctrLoad   = 1'b0;
        ctrInit   = '0;
        blkValid  = 1'b0;
        ksReady   = 1'b0;
        set_blk(32'h0);
`ifdef CHACHA_KS_XOR_EN
        ptWord = 32'hFFFF_FFFF;
`endif

        //          clr  load init   bv   rdy  base          valid word          last brdy ctr    wrap
        tbl[0] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 32'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'd5, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b1, 32'd5, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'hA000_0000, 1'b1, 32'hA000_0000, 1'b0, 1'b1, 32'd6, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hB000_0000, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 32'd7, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'hC000_0000, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 32'd7, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 32'h0,       1'b1, 32'hA000_0002, 1'b0, 1'b0, 32'd7, 1'b0};

        // Table: each row's inputs cross one edge, then outputs are compared.
        for (int r = 0; r < 6; r++) begin
            clrStream = tbl[r].clr;
            ctrLoad   = tbl[r].load;
            ctrInit   = tbl[r].init;
            blkValid  = tbl[r].bv;
            ksReady   = tbl[r].rdy;
            set_blk(tbl[r].base);
            step();
            chk($sformatf("row%0d ksValid", r), 32'(ksValid), 32'(tbl[r].e_valid));
            chk($sformatf("row%0d ksWord", r), ksWord, tbl[r].e_word);
            chk($sformatf("row%0d ksLast", r), 32'(ksLast), 32'(tbl[r].e_last));
            chk($sformatf("row%0d blkReady", r), 32'(blkReady), 32'(tbl[r].e_brdy));
            chk($sformatf("row%0d blockCtr", r), blockCtr, tbl[r].e_ctr);
            chk($sformatf("row%0d ctrWrap", r), 32'(ctrWrap), 32'(tbl[r].e_wrap));
        end

        // Single block, full rate.
        do_reset();
        set_blk(32'h1000_0000);
        blkValid = 1'b1;
        ksReady  = 1'b1;
        step();
        blkValid = 1'b0;
        drain("single", 32'h1000_0000);
        chk("single ctr", blockCtr, 32'd1);

        // Two blocks back-to-back while stalled, third held off, then no bubble.
        do_reset();
        ksReady = 1'b0;
        set_blk(32'h2000_0000);
        blkValid = 1'b1;
        step();
        chk("b2b ready after 1st", 32'(blkReady), 32'd1);
        set_blk(32'h3000_0000);
        step();
        chk("b2b ready after 2nd", 32'(blkReady), 32'd0);
        set_blk(32'h4000_0000);
        step();
        step();
        chk("b2b third held", 32'(blkReady), 32'd0);
        chk("b2b ctr", blockCtr, 32'd2);
        blkValid = 1'b0;
        ksReady  = 1'b1;
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("b2b valid%0d", k), 32'(ksValid), 32'd1);
            chk($sformatf("b2b word%0d", k), ksWord,
                (k < 16) ? 32'h2000_0000 + 32'(k) : 32'h3000_0000 + 32'(k - 16));
            step();
        end
        chk("b2b idle", 32'(ksValid), 32'd0);

        // Stall pattern 1,0,0,1: every word appears exactly once, in order.
        do_reset();
        set_blk(32'h5000_0000);
        blkValid = 1'b1;
        ksReady  = 1'b0;
        step();
        blkValid = 1'b0;
        pat   = 4'b1001;
        exp_i = 0;
        cyc   = 0;
        while (exp_i < 16 && cyc < 100) begin
            ksReady = pat[cyc % 4];
            chk($sformatf("stall valid c%0d", cyc), 32'(ksValid), 32'd1);
            chk($sformatf("stall word c%0d", cyc), ksWord, 32'h5000_0000 + 32'(exp_i));
            chk($sformatf("stall last c%0d", cyc), 32'(ksLast), 32'(exp_i == 15));
            step();
            if (ksReady) exp_i++;
            cyc++;
        end
        chk("stall timeout", 32'(cyc < 100), 32'd1);
        chk("stall idle", 32'(ksValid), 32'd0);

        // Counter wrap: load all-ones, accept one block.
        do_reset();
        ctrLoad = 1'b1;
        ctrInit = 32'hFFFF_FFFF;
        step();
        ctrLoad = 1'b0;
        chk("wrap loaded", blockCtr, 32'hFFFF_FFFF);
        set_blk(32'h6000_0000);
        blkValid = 1'b1;
        step();
        blkValid = 1'b0;
        chk("wrap ctr", blockCtr, 32'd0);
        chk("wrap flag", 32'(ctrWrap), 32'd1);
        chk("wrap ready", 32'(blkReady), 32'd0);
        drain("wrap", 32'h6000_0000);
        chk("wrap ready drained", 32'(blkReady), 32'd0);
        chk("wrap sticky", 32'(ctrWrap), 32'd1);
        ctrLoad = 1'b1;
        ctrInit = 32'd0;
        step();
        ctrLoad = 1'b0;
        chk("wrap cleared", 32'(ctrWrap), 32'd0);
        chk("wrap ready again", 32'(blkReady), 32'd1);

        // Load together with accept: load wins; then clear mid-block.
        do_reset();
        ctrLoad  = 1'b1;
        ctrInit  = 32'h0000_0055;
        set_blk(32'h7000_0000);
        blkValid = 1'b1;
        step();
        ctrLoad  = 1'b0;
        blkValid = 1'b0;
        chk("loadacc ctr", blockCtr, 32'h0000_0055);
        chk("loadacc valid", 32'(ksValid), 32'd1);
        ksReady = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("clr pre word", ksWord, 32'h7000_0006);
        clrStream = 1'b1;
        step();
        chk("clr ksValid", 32'(ksValid), 32'd0);
        chk("clr ksWord", ksWord, 32'd0);
        chk("clr ksLast", 32'(ksLast), 32'd0);
        chk("clr ctr", blockCtr, 32'd0);
        chk("clr ready during", 32'(blkReady), 32'd0);
        clrStream = 1'b0;
        #1;
        chk("clr ready after", 32'(blkReady), 32'd1);
        step();
        chk("clr stays empty", 32'(ksValid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
